decode_n_seq: RTL and testbench

//   Parametrised, registered binary-to-one-hot decoder. Generalises the fixed 3-to-8 decoder.
//   Two modes:
//   - Direct: a code is loaded over a valid/ready handshake and decoded.
//   - Scan: the block steps the one-hot output through all 2**N lines with a programmable dwell time.

---
 rtl/decode_n_seq.sv | 120 ++++++++++++
 tb/tb_decode_n_seq.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_n_seq.sv
// decode_n_seq: registered binary-to-one-hot decoder with a direct-load mode
// (valid/ready code transfer) and an auto-scan mode that steps the selected
// line through all 2**N outputs with a programmable dwell per line.
module decode_n_seq #(
    parameter int unsigned N          = 3,
    parameter int unsigned DWELL_W    = 8,
    parameter bit          ACTIVE_LOW = 1'b0,
    localparam int unsigned OUT_W     = 2 ** N
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               En,
    input  logic               Mode,
    input  logic [N-1:0]       I,
    input  logic               I_valid,
    output logic               I_ready,
    input  logic [DWELL_W-1:0] Dwell,
    output logic [OUT_W-1:0]   Y,
    output logic [N-1:0]       Idx,
    output logic               Wrap
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        SCAN = 2'd2
    } state_t;

    localparam logic [OUT_W-1:0] Y_INACTIVE = {OUT_W{ACTIVE_LOW}};

    state_t             state_q;
    logic [N-1:0]       idx_q;
    logic [N-1:0]       idx_d;
    logic [DWELL_W-1:0] cnt_q;
    logic [DWELL_W-1:0] cnt_d;
    logic [OUT_W-1:0]   y_q;
    logic [OUT_W-1:0]   y_d;
    logic               wrap_q;
    logic               wrap_d;
    logic               xfer_c;

    // Ready whenever in direct mode and out of reset; a code moves on valid & ready.
    assign I_ready = ~Mode & ~rst;
    assign xfer_c  = I_valid & I_ready;

    // Next index, dwell count, wrap pulse and decoded output pattern.
    always_comb begin
        idx_d  = idx_q;
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        y_d    = '0;
        if (Mode) begin
            if (state_q != SCAN) begin
                // First scan edge: start the current line with a fresh dwell.
                cnt_d = '0;
            end else if (En) begin
                // >= so that shrinking Dwell below cnt steps immediately.
                if (cnt_q >= Dwell) begin
                    cnt_d  = '0;
                    idx_d  = idx_q + N'(1);
                    wrap_d = (idx_q == {N{1'b1}});
                end else begin
                    cnt_d = cnt_q + DWELL_W'(1);
                end
            end
        end else begin
            cnt_d = '0;
            if (xfer_c) begin
                idx_d = I;
            end
        end
        if (En) begin
            y_d = OUT_W'(1) << idx_d;
        end
        if (ACTIVE_LOW) begin
            y_d = ~y_d;
        end
    end

    // Mode/transfer state machine plus all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            y_q     <= Y_INACTIVE;
            wrap_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (Mode) begin
                        state_q <= SCAN;
                    end else if (xfer_c) begin
                        state_q <= HOLD;
                    end
                end
                HOLD: begin
                    if (Mode) begin
                        state_q <= SCAN;
                    end
                end
                SCAN: begin
                    if (!Mode) begin
                        state_q <= HOLD;
                    end
                end
                default: state_q <= IDLE;
            endcase
            idx_q  <= idx_d;
            cnt_q  <= cnt_d;
            y_q    <= y_d;
            wrap_q <= wrap_d;
        end
    end

    assign Y    = y_q;
    assign Idx  = idx_q;
    assign Wrap = wrap_q;

endmodule

// File: tb/tb_decode_n_seq.sv
// tb_decode_n_seq: drives two decoder instances (N=3 active-high, N=4
// active-low) from shared stimulus; a reference model pushes expected
// outputs per clock into a queue and a monitor pops and compares them.
module tb_decode_n_seq;

    typedef struct {
        int         idx;
        int         cnt;
        bit         scanning;
        bit         wrap;
        logic [15:0] y;
    } model_t;

    typedef struct {
        model_t a;
        model_t b;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        en;
    logic        mode;
    logic [3:0]  i_drv;
    logic        iv;
    logic [7:0]  dwell;

    logic        ready3;
    logic [7:0]  y3;
    logic [2:0]  idx3;
    logic        wrap3;
    logic        ready4;
    logic [15:0] y4;
    logic [3:0]  idx4;
    logic        wrap4;

    int checks = 0;
    int errors = 0;

    exp_t   q[$];
    exp_t   mon_e;
    model_t m3;
    model_t m4;

    decode_n_seq #(.N(3), .DWELL_W(8), .ACTIVE_LOW(1'b0)) dut3 (
        .clk(clk), .rst(rst), .En(en), .Mode(mode), .I(i_drv[2:0]),
        .I_valid(iv), .I_ready(ready3), .Dwell(dwell),
        .Y(y3), .Idx(idx3), .Wrap(wrap3)
    );

    decode_n_seq #(.N(4), .DWELL_W(8), .ACTIVE_LOW(1'b1)) dut4 (
        .clk(clk), .rst(rst), .En(en), .Mode(mode), .I(i_drv),
        .I_valid(iv), .I_ready(ready4), .Dwell(dwell),
        .Y(y4), .Idx(idx4), .Wrap(wrap4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic model_t m_reset(int n, bit al);
        model_t r;
        r.idx      = 0;
        r.cnt      = 0;
        r.scanning = 1'b0;
        r.wrap     = 1'b0;
        r.y        = al ? 16'((1 << (1 << n)) - 1) : 16'h0;
        return r;
    endfunction

    // One clock edge of the decoder, stated directly from its rules.
    function automatic model_t m_step(model_t m, int n, bit al, bit en_s,
                                      bit mode_s, bit iv_s, int i_s, int dw_s);
        model_t      r;
        int          lines;
        logic [15:0] oh;
        lines  = 1 << n;
        r      = m;
        r.wrap = 1'b0;
        if (mode_s) begin
            if (!m.scanning) begin
                r.scanning = 1'b1;
                r.cnt      = 0;
            end else if (en_s) begin
                if (m.cnt >= dw_s) begin
                    r.cnt = 0;
                    r.idx = (m.idx + 1) % lines;
                    r.wrap = (r.idx == 0);
                end else begin
                    r.cnt = m.cnt + 1;
                end
            end
        end else begin
            r.scanning = 1'b0;
            r.cnt      = 0;
            if (iv_s) r.idx = i_s % lines;
        end
        oh = en_s ? 16'(1 << r.idx) : 16'h0;
        if (al) oh = ~oh & 16'((1 << lines) - 1);
        r.y = oh;
        return r;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model advances on every clock edge and queues the expectation.
    always @(posedge clk) begin
        exp_t e;
        if (rst) begin
            m3 = m_reset(3, 1'b0);
            m4 = m_reset(4, 1'b1);
        end else begin
            m3 = m_step(m3, 3, 1'b0, en, mode, iv, int'(i_drv), int'(dwell));
            m4 = m_step(m4, 4, 1'b1, en, mode, iv, int'(i_drv), int'(dwell));
        end
        e.a = m3;
        e.b = m4;
        q.push_back(e);
    end

    // Asynchronous reset overrides any expectation still waiting in the queue.
    always @(posedge rst) begin
        exp_t e;
        m3  = m_reset(3, 1'b0);
        m4  = m_reset(4, 1'b1);
        e.a = m3;
        e.b = m4;
        if (q.size() > 0) begin
            q.delete();
            q.push_back(e);
        end
    end

    // Monitor: compare DUT outputs against the oldest expectation each cycle.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            chk("y3",    32'(y3),    32'(mon_e.a.y[7:0]));
            chk("idx3",  32'(idx3),  32'(mon_e.a.idx));
            chk("wrap3", 32'(wrap3), 32'(mon_e.a.wrap));
            chk("y4",    32'(y4),    32'(mon_e.b.y));
            chk("idx4",  32'(idx4),  32'(mon_e.b.idx));
            chk("wrap4", 32'(wrap4), 32'(mon_e.b.wrap));
            if (!rst) begin
                chk("ready3", 32'(ready3), 32'(!mode));
                chk("ready4", 32'(ready4), 32'(!mode));
            end
        end
    end

    task automatic cyc(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(bit e, bit md, bit v, int code, int dw);
        en    = e;
        mode  = md;
        iv    = v;
        i_drv = 4'(code);
        dwell = 8'(dw);
    endtask

    initial begin
        rst = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 0, 0);
        #1 rst = 1'b1;
        #1;
        chk("rst_y3",    32'(y3),    32'h00);
        chk("rst_y4",    32'(y4),    32'hFFFF);
        chk("rst_idx3",  32'(idx3),  32'h0);
        chk("rst_wrap3", 32'(wrap3), 32'h0);
        cyc(2);
        rst = 1'b0;

        // Idle after reset, no valid code.
        cyc(5);
        // Direct loads: 5 then 0.
        drive(1'b1, 1'b0, 1'b1, 5, 0); cyc(1);
        drive(1'b1, 1'b0, 1'b0, 5, 0); cyc(2);
        drive(1'b1, 1'b0, 1'b1, 0, 0); cyc(1);
        drive(1'b1, 1'b0, 1'b0, 0, 0); cyc(2);
        // Scan from 6 with dwell 2 through a wrap.
        drive(1'b1, 1'b0, 1'b1, 6, 2); cyc(1);
        drive(1'b1, 1'b1, 1'b0, 6, 2); cyc(14);
        // Enable gating mid-scan.
        drive(1'b0, 1'b1, 1'b0, 6, 2); cyc(4);
        drive(1'b1, 1'b1, 1'b0, 6, 2); cyc(5);
        // Back to direct, then 0->1 with a pending code, then 1->0 loads it.
        drive(1'b1, 1'b0, 1'b0, 1, 2); cyc(2);
        drive(1'b1, 1'b1, 1'b1, 3, 1); cyc(4);
        drive(1'b1, 1'b0, 1'b1, 3, 1); cyc(1);
        drive(1'b1, 1'b0, 1'b0, 3, 1); cyc(2);
        // Full-scale code on the 4-bit instance.
        drive(1'b1, 1'b0, 1'b1, 15, 0); cyc(1);
        drive(1'b1, 1'b0, 1'b0, 15, 0); cyc(2);
        // Shrink dwell below current count.
        drive(1'b1, 1'b1, 1'b0, 0, 7); cyc(5);
        drive(1'b1, 1'b1, 1'b0, 0, 1); cyc(4);
        // Asynchronous reset mid-scan, observed before the next edge.
        rst = 1'b1;
        #1;
        chk("async_y4",   32'(y4),   32'hFFFF);
        chk("async_y3",   32'(y3),   32'h00);
        chk("async_idx4", 32'(idx4), 32'h0);
        cyc(1);
        rst = 1'b0;
        cyc(2);

        // Randomised phase.
        for (int k = 0; k < 600; k++) begin
            bit e;
            bit md;
            int dw;
            e  = ($urandom_range(0, 7) != 0);
            md = ($urandom_range(0, 15) == 0) ? !mode : mode;
            dw = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 12))
                                              : int'($urandom_range(0, 2));
            drive(e, md, 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), dw);
            if ($urandom_range(0, 99) == 0) begin
                rst = 1'b1;
                cyc(1);
                rst = 1'b0;
            end else begin
                cyc(1);
            end
        end

        drive(1'b1, 1'b0, 1'b0, 0, 0);
        cyc(3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
